// File: rtl/operand_aligner.sv
// Operand aligner: buffers four independent valid/ready operand channels in
// per-channel FIFOs and emits one aligned (a,b,c,d) tuple when all hold data.
module operand_aligner #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  artsn_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [DATA_WIDTH-1:0] c_i,
    input  logic                  c_valid_i,
    output logic                  c_ready_o,
    input  logic [DATA_WIDTH-1:0] d_i,
    input  logic                  d_valid_i,
    output logic                  d_ready_o,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [DATA_WIDTH-1:0] c_o,
    output logic [DATA_WIDTH-1:0] d_o,
    output logic                  valid_o,
    output logic                  overflow_o,
    output logic [CNT_WIDTH-1:0]  tuple_cnt_o
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] w_din   [NCH];
    logic                  w_valid [NCH];
    logic                  w_ready [NCH];
    logic                  w_push  [NCH];
    logic                  w_pop;
    logic                  w_ovf;

    logic [DATA_WIDTH-1:0] r_mem  [NCH][DEPTH];
    logic [PTR_W-1:0]      r_wptr [NCH];
    logic [PTR_W-1:0]      r_rptr [NCH];
    logic [CW-1:0]         r_cnt  [NCH];

    logic [DATA_WIDTH-1:0] r_a_o;
    logic [DATA_WIDTH-1:0] r_b_o;
    logic [DATA_WIDTH-1:0] r_c_o;
    logic [DATA_WIDTH-1:0] r_d_o;
    logic                  r_valid_o;
    logic                  r_overflow_o;
    logic [CNT_WIDTH-1:0]  r_tuple_cnt;

    assign w_din[0]   = a_i;
    assign w_din[1]   = b_i;
    assign w_din[2]   = c_i;
    assign w_din[3]   = d_i;
    assign w_valid[0] = a_valid_i;
    assign w_valid[1] = b_valid_i;
    assign w_valid[2] = c_valid_i;
    assign w_valid[3] = d_valid_i;

    // Ready, push, pop and overflow decode from registered counts only (no bypass).
    always_comb begin
        w_pop = 1'b1;
        w_ovf = 1'b0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            w_ready[ch] = artsn_i && (r_cnt[ch] < FULL_CNT);
            w_push[ch]  = w_valid[ch] && w_ready[ch];
            w_pop       = w_pop && (r_cnt[ch] != '0);
            w_ovf       = w_ovf || (w_valid[ch] && !w_ready[ch]);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (!artsn_i) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                r_wptr[ch] <= '0;
                r_rptr[ch] <= '0;
                r_cnt[ch]  <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                if (w_push[ch]) begin
                    r_wptr[ch] <= r_wptr[ch] + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr[ch] <= r_rptr[ch] + PTR_W'(1);
                end
                case ({w_push[ch], w_pop})
                    2'b10:   r_cnt[ch] <= r_cnt[ch] + CW'(1);
                    2'b01:   r_cnt[ch] <= r_cnt[ch] - CW'(1);
                    default: r_cnt[ch] <= r_cnt[ch];
                endcase
            end
        end
    end

    // Storage needs no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk_i) begin
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (w_push[ch]) begin
                r_mem[ch][r_wptr[ch]] <= w_din[ch];
            end
        end
    end

    // Output tuple, valid pulse, sticky overflow and tuple counter
    always_ff @(posedge clk_i) begin
        if (!artsn_i) begin
            r_a_o        <= '0;
            r_b_o        <= '0;
            r_c_o        <= '0;
            r_d_o        <= '0;
            r_valid_o    <= 1'b0;
            r_overflow_o <= 1'b0;
            r_tuple_cnt  <= '0;
        end else begin
            r_valid_o    <= w_pop;
            r_overflow_o <= r_overflow_o || w_ovf;
            if (w_pop) begin
                r_a_o       <= r_mem[0][r_rptr[0]];
                r_b_o       <= r_mem[1][r_rptr[1]];
                r_c_o       <= r_mem[2][r_rptr[2]];
                r_d_o       <= r_mem[3][r_rptr[3]];
                r_tuple_cnt <= r_tuple_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign a_ready_o   = w_ready[0];
    assign b_ready_o   = w_ready[1];
    assign c_ready_o   = w_ready[2];
    assign d_ready_o   = w_ready[3];
    assign a_o         = r_a_o;
    assign b_o         = r_b_o;
    assign c_o         = r_c_o;
    assign d_o         = r_d_o;
    assign valid_o     = r_valid_o;
    assign overflow_o  = r_overflow_o;
    assign tuple_cnt_o = r_tuple_cnt;

endmodule

// File: tb/tb_operand_aligner.sv
// Directed bench for operand_aligner: hand-computed tuples, ready/overflow
// behaviour, mid-stream reset and tuple counter wrap.
module tb_operand_aligner;

    logic        clk_i = 1'b0;
    logic        artsn_i;
    logic [31:0] a_i, b_i, c_i, d_i;
    logic        a_valid_i, b_valid_i, c_valid_i, d_valid_i;
    logic        a_ready_o, b_ready_o, c_ready_o, d_ready_o;
    logic [31:0] a_o, b_o, c_o, d_o;
    logic        valid_o, overflow_o;
    logic [15:0] tuple_cnt_o;

    int n_total = 0;
    int n_pass  = 0;

    logic [127:0] got_q [$];
    int           run_len = 0;
    int           max_run = 0;

    always #5 clk_i = ~clk_i;

    operand_aligner #(.DATA_WIDTH(32), .DEPTH(4), .CNT_WIDTH(16)) u_dut (
        .clk_i       (clk_i),
        .artsn_i     (artsn_i),
        .a_i         (a_i),
        .a_valid_i   (a_valid_i),
        .a_ready_o   (a_ready_o),
        .b_i         (b_i),
        .b_valid_i   (b_valid_i),
        .b_ready_o   (b_ready_o),
        .c_i         (c_i),
        .c_valid_i   (c_valid_i),
        .c_ready_o   (c_ready_o),
        .d_i         (d_i),
        .d_valid_i   (d_valid_i),
        .d_ready_o   (d_ready_o),
        .a_o         (a_o),
        .b_o         (b_o),
        .c_o         (c_o),
        .d_o         (d_o),
        .valid_o     (valid_o),
        .overflow_o  (overflow_o),
        .tuple_cnt_o (tuple_cnt_o)
    );

    // Collect emitted tuples and longest run of consecutive valid cycles.
    always @(negedge clk_i) begin
        if (artsn_i === 1'b1 && valid_o === 1'b1) begin
            got_q.push_back({a_o, b_o, c_o, d_o});
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        {a_valid_i, b_valid_i, c_valid_i, d_valid_i} = m;
        a_i = a; b_i = b; c_i = c; d_i = d;
        tick();
        {a_valid_i, b_valid_i, c_valid_i, d_valid_i} = 4'b0000;
    endtask

    task automatic do_reset();
        artsn_i = 1'b0;
        tick();
        check("rst_tuple", {a_o, b_o, c_o, d_o}, 128'd0);
        check("rst_valid", valid_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_cnt", tuple_cnt_o, 0);
        check("rst_ready", {a_ready_o, b_ready_o, c_ready_o, d_ready_o}, 4'b0000);
        artsn_i = 1'b1;
        #1;
        check("post_rst_ready", {a_ready_o, b_ready_o, c_ready_o, d_ready_o}, 4'b1111);
        got_q.delete();
        max_run = 0;
    endtask

    initial begin
        int q;
        artsn_i = 1'b0;
        {a_valid_i, b_valid_i, c_valid_i, d_valid_i} = 4'b0000;
        a_i = '0; b_i = '0; c_i = '0; d_i = '0;
        tick();

        // 1: single aligned tuple, latency and core result
        do_reset();
        drive(4'b1111, 32'd10, 32'd4, 32'd2, 32'd1);
        check("t1_no_bypass", valid_o, 0);
        tick();
        check("t1_valid", valid_o, 1);
        check("t1_tuple", {a_o, b_o, c_o, d_o}, {32'd10, 32'd4, 32'd2, 32'd1});
        check("t1_cnt", tuple_cnt_o, 1);
        q = ((int'(a_o) - int'(b_o)) * (1 + 3 * int'(c_o)) - 4 * int'(d_o)) / 2;
        check("t1_core_q", 32'(q), 32'd19);
        tick();
        check("t1_pulse_end", valid_o, 0);
        check("t1_hold", {a_o, b_o, c_o, d_o}, {32'd10, 32'd4, 32'd2, 32'd1});

        // 2: staggered arrival a@0 b@3 c@5 d@9
        do_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive({cyc == 0, cyc == 3, cyc == 5, cyc == 9}, 32'd21, 32'd22, 32'd23, 32'd24);
            check($sformatf("t2_early_%0d", cyc), valid_o, 0);
        end
        tick();
        check("t2_valid", valid_o, 1);
        check("t2_tuple", {a_o, b_o, c_o, d_o}, {32'd21, 32'd22, 32'd23, 32'd24});
        tick();
        check("t2_count", got_q.size(), 1);

        // 3: fill channel a past DEPTH, then drain with b/c/d
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_aready_%0d", i), a_ready_o, (i < 4) ? 1 : 0);
            check($sformatf("t3_ovf_before_%0d", i), overflow_o, 0);
            drive(4'b1000, 32'(100 + i), 0, 0, 0);
        end
        check("t3_ovf_set", overflow_o, 1);
        for (int i = 0; i < 4; i++) begin
            drive(4'b0111, 0, 32'(200 + i), 32'(300 + i), 32'(400 + i));
        end
        repeat (3) tick();
        check("t3_ntuples", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size())
                check($sformatf("t3_tuple_%0d", i), got_q[i],
                      {32'(100 + i), 32'(200 + i), 32'(300 + i), 32'(400 + i)});
        end
        check("t3_ovf_sticky", overflow_o, 1);
        check("t3_aready_back", a_ready_o, 1);
        check("t3_cnt", tuple_cnt_o, 4);

        // 4: all channels streaming 1..8
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(4'b1111, 32'(i), 32'(i), 32'(i), 32'(i));
        end
        repeat (3) tick();
        check("t4_run", max_run, 8);
        check("t4_ntuples", got_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size())
                check($sformatf("t4_tuple_%0d", i), got_q[i],
                      {32'(i + 1), 32'(i + 1), 32'(i + 1), 32'(i + 1)});
        end
        check("t4_cnt", tuple_cnt_o, 8);

        // 5: reset discards partially buffered operands
        do_reset();
        drive(4'b1110, 32'd1, 32'd2, 32'd3, 0);
        drive(4'b1110, 32'd4, 32'd5, 32'd6, 0);
        artsn_i = 1'b0;
        tick();
        check("t5_rst_valid", valid_o, 0);
        artsn_i = 1'b1;
        got_q.delete();
        drive(4'b1111, 32'd55, 32'd66, 32'd77, 32'd88);
        repeat (4) tick();
        check("t5_ntuples", got_q.size(), 1);
        if (got_q.size() > 0)
            check("t5_tuple", got_q[0], {32'd55, 32'd66, 32'd77, 32'd88});
        check("t5_cnt", tuple_cnt_o, 1);

        // 6: tuple counter wrap
        do_reset();
        {a_valid_i, b_valid_i, c_valid_i, d_valid_i} = 4'b1111;
        a_i = 32'd7; b_i = 32'd3; c_i = 32'd1; d_i = 32'd2;
        repeat (65535) tick();
        {a_valid_i, b_valid_i, c_valid_i, d_valid_i} = 4'b0000;
        tick();
        check("t6_cnt_max", tuple_cnt_o, 16'hFFFF);
        check("t6_ovf", overflow_o, 0);
        tick();
        got_q.delete();
        drive(4'b1111, 32'd9, 32'd8, 32'd7, 32'd6);
        tick();
        check("t6_valid", valid_o, 1);
        check("t6_cnt_wrap", tuple_cnt_o, 16'h0000);
        check("t6_tuple", {a_o, b_o, c_o, d_o}, {32'd9, 32'd8, 32'd7, 32'd6});
        tick();
        check("t6_ntuples", got_q.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/operand_aligner.md
Name: operand_aligner

Overview:
Upstream stage of the arithmetic core `top`. The core computes q = ((a-b)*(1+3c) - 4d)/2 and requires a, b, c and d to be presented together with all four valids high in the same cycle. This block accepts the four operands on independent valid/ready channels, so they may arrive at different times. It buffers each channel in a small FIFO and emits one aligned tuple whenever every channel holds at least one word. Its outputs drive the core's a_i..d_i directly, and valid_o fans out to all four of the core's valid inputs.

Parameters:
DATA_WIDTH, 32, operand width in bits.
DEPTH, 4, entries per channel FIFO; power of two, minimum 2.
CNT_WIDTH, 16, width of the emitted-tuple counter.

Ports:
clk_i  in  1  clock; all logic on rising edge.
artsn_i  in  1  reset, synchronous, active-low.
a_i  in  DATA_WIDTH  operand a.
a_valid_i  in  1  a_i valid.
a_ready_o  out  1  channel a can accept.
b_i / b_valid_i / b_ready_o  in/in/out  DATA_WIDTH/1/1  as channel a.
c_i / c_valid_i / c_ready_o  in/in/out  DATA_WIDTH/1/1  as channel a.
d_i / d_valid_i / d_ready_o  in/in/out  DATA_WIDTH/1/1  as channel a.
a_o, b_o, c_o, d_o  out  DATA_WIDTH each  aligned tuple to core.
valid_o  out  1  tuple valid; one-cycle pulse per tuple.
overflow_o  out  1  sticky flag: a write was attempted while ready was low.
tuple_cnt_o  out  CNT_WIDTH  number of tuples emitted.

Behaviour:
- Reset is synchronous and active-low. With artsn_i low at a rising edge:
  - all FIFOs are emptied (pointers and counts cleared);
  - a_o..d_o = 0, valid_o = 0, overflow_o = 0, tuple_cnt_o = 0;
  - all x_ready_o = 0 while artsn_i is low.
- Reset mid-operation discards buffered words. A tuple in flight is dropped and no valid_o pulse follows.
- Per channel x:
  - x_ready_o = (count_x < DEPTH), decoded combinationally from the registered count.
  - A word is accepted at an edge where x_valid_i && x_ready_o.
- A full FIFO never accepts a write, even when a pop happens in the same cycle. Ready rises in the cycle after the pop.
- Overflow: x_valid_i high with x_ready_o low at any non-reset edge sets overflow_o. The word is dropped. overflow_o stays high until reset.
- Pop condition, evaluated on registered counts: count_a, count_b, count_c and count_d are all nonzero.
  - When it holds at edge k, the heads of all four FIFOs pop together at edge k.
  - After edge k: a_o..d_o = the popped heads, valid_o = 1, tuple_cnt_o increments by 1.
- There is no bypass. A word accepted at edge k is not visible to the pop logic until after edge k. Minimum latency from the last operand accepted to valid_o high is therefore 1 cycle (pop at edge k+1, valid_o high during cycle k+1 to k+2).
- Simultaneous push and pop on a non-full FIFO in the same cycle: the count is unchanged and both operations complete.
- Back-to-back: if all counts stay nonzero, a tuple pops every cycle and valid_o remains high continuously.
- When valid_o = 0, a_o..d_o hold their last values.
- Ordering: each channel is strictly FIFO. Tuple n pairs the n-th accepted word of every channel.
- tuple_cnt_o wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- There is no downstream backpressure. The core always accepts.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

Test Plan:
1. Reset, then a=10, b=4, c=2, d=1, all valid in one cycle -> valid_o is a single pulse 2 edges later with a_o=10, b_o=4, c_o=2, d_o=1; tuple_cnt_o=1; the core's q_o=19.
2. Staggered arrival: a at cycle 0, b at 3, c at 5, d at 9 -> no valid_o before the edge after d is accepted; then one pulse with the correct tuple.
3. Fill channel a with DEPTH+1 words while b, c and d stay idle:
   - a_ready_o falls after 4 words;
   - the 5th word is dropped and overflow_o=1;
   - then drive 4 words on b, c and d -> 4 tuples in order with a=first 4 words; overflow_o stays 1 until reset.
4. All channels streaming every cycle with values 1..8 -> valid_o high for 8 consecutive cycles, tuples (i,i,i,i) in order, tuple_cnt_o=8.
5. Push 2 words on each of a, b and c only, assert artsn_i low for 1 cycle, then drive one full tuple -> exactly one valid_o pulse carrying the post-reset tuple; tuple_cnt_o=1.
6. Preload tuple_cnt_o to 0xFFFF by emitting 65535 tuples, then emit 1 more -> tuple_cnt_o=0x0000; other behaviour unaffected.
